// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's core-side and instruction-memory-side signals.
// master = the fetch unit itself; slave = the core/memory environment around it.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] pc_in;
  logic              fetch_req;
  logic              flush;
  logic              instr_ready;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] immediate_value;
  logic              instr_valid;
  logic              fetch_busy;
  logic              fetch_err;

  modport master (
    input  pc_in, fetch_req, flush, instr_ready, mem_ready, mem_rdata,
    output mem_rd, mem_addr, instr_out, immediate_value, instr_valid,
           fetch_busy, fetch_err
  );

  modport slave (
    output pc_in, fetch_req, flush, instr_ready, mem_ready, mem_rdata,
    input  mem_rd, mem_addr, instr_out, immediate_value, instr_valid,
           fetch_busy, fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: ready/valid read from instruction memory, branch flush,
// sign-extended immediate. Optional memory timeout enabled by FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int IMM_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_imm;
  logic              r_valid;
  logic              r_busy;
  logic              w_timeout;
  logic              w_launch;
  logic              w_capture;

  // The wait counter is 4 bits wide; a TIMEOUT outside 1..15 can never be reached.
  if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_timeout_out_of_range
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] LP_TMO_LAST = 4'(TIMEOUT - 1);

  logic [3:0] r_wait_cnt;
  logic       r_err;

  assign w_timeout = ((r_state == S_WAIT) || (r_state == S_DRAIN)) &&
                     !bus.mem_ready && (r_wait_cnt == LP_TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_launch) begin
        r_wait_cnt <= '0;
      end else if (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !bus.mem_ready) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end
  end

  assign bus.fetch_err = r_err;
`else
  assign w_timeout     = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.fetch_req && !bus.flush) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // flush beats a same-cycle mem_ready: the beat completes the read, so skip DRAIN
        if (w_timeout)                         w_state_nxt = S_IDLE;
        else if (bus.flush && bus.mem_ready)   w_state_nxt = S_IDLE;
        else if (bus.flush)                    w_state_nxt = S_DRAIN;
        else if (bus.mem_ready)                w_state_nxt = S_VALID;
      end
      S_DRAIN: begin
        if (w_timeout || bus.mem_ready) w_state_nxt = S_IDLE;
      end
      S_VALID: begin
        if (bus.flush)                                w_state_nxt = S_IDLE;
        else if (bus.instr_ready && bus.fetch_req)    w_state_nxt = S_WAIT;
        else if (bus.instr_ready)                     w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_launch  = (w_state_nxt == S_WAIT) && (r_state != S_WAIT);
  assign w_capture = (r_state == S_WAIT) && (w_state_nxt == S_VALID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_instr    <= '0;
      r_imm      <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_valid  <= (w_state_nxt == S_VALID);
      r_mem_rd <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_DRAIN);
      if (w_launch) begin
        r_mem_addr <= bus.pc_in;
      end
      if (w_capture) begin
        r_instr <= bus.mem_rdata;
        r_imm   <= {{(ADDR_W-IMM_W){bus.mem_rdata[IMM_W-1]}}, bus.mem_rdata[IMM_W-1:0]};
      end
    end
  end

  assign bus.mem_rd          = r_mem_rd;
  assign bus.mem_addr        = r_mem_addr;
  assign bus.instr_out       = r_instr;
  assign bus.immediate_value = r_imm;
  assign bus.instr_valid     = r_valid;
  assign bus.fetch_busy      = r_busy;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a wait-stated memory model and
// latency/immediate rules computed arithmetically.
module tb_instr_fetch_unit;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .IMM_W(IW), .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int unsigned mq_wait[$];
  logic [15:0] mq_data[$];
  bit          m_active = 1'b0;
  int unsigned m_left = 0;
  logic [15:0] m_data = '0;
  bit          force_ready = 1'b0;
  logic [15:0] force_data = 16'hDEAD;

  // Memory: each new read burns its queued wait count, then returns its queued data.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (force_ready) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = force_data;
      end else if (bus.mem_rd !== 1'b1) begin
        m_active      = 1'b0;
        bus.mem_ready = 1'b0;
      end else begin
        if (!m_active) begin
          m_active = 1'b1;
          m_left   = (mq_wait.size() > 0) ? mq_wait.pop_front() : 0;
          m_data   = (mq_data.size() > 0) ? mq_data.pop_front() : 16'h0000;
        end
        if (m_left > 0) begin
          bus.mem_ready = 1'b0;
          m_left--;
        end else begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = m_data;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_imm(input logic [15:0] d);
    int v;
    v = int'(d[7:0]);
    if (v >= 128) v = v - 256;
    return 16'(v);
  endfunction

  task automatic fetch_one(input logic [15:0] pc, input logic [15:0] d,
                           input int unsigned w, input int unsigned hold);
    int unsigned cyc;
    int unsigned rd_cyc;
    bit          addr_ok;
    mq_wait.push_back(w);
    mq_data.push_back(d);
    bus.pc_in     = pc;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    bus.pc_in     = 16'($urandom);
    cyc = 1; rd_cyc = 0; addr_ok = 1'b1;
    while (bus.instr_valid !== 1'b1 && cyc < 40) begin
      if (bus.mem_rd === 1'b1) begin
        rd_cyc++;
        if (bus.mem_addr !== pc) addr_ok = 1'b0;
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 2 + w) begin
      errors++; $display("FAIL latency: got %0d cycles expected %0d", cyc, 2 + w);
    end
    checks++;
    if (rd_cyc !== w + 1 || !addr_ok) begin
      errors++; $display("FAIL mem_rd_hold: got %0d cycles addr_ok=%0d expected %0d cycles addr_ok=1", rd_cyc, addr_ok, w + 1);
    end
    checks++;
    if (bus.instr_out !== d || bus.immediate_value !== ref_imm(d)) begin
      errors++; $display("FAIL fetch_data: got instr=%h imm=%h expected instr=%h imm=%h", bus.instr_out, bus.immediate_value, d, ref_imm(d));
    end
    for (int unsigned h = 0; h < hold; h++) begin
      tick();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_out !== d || bus.mem_rd !== 1'b0) begin
        errors++; $display("FAIL valid_hold: got valid=%b instr=%h mem_rd=%b expected 1 %h 0", bus.instr_valid, bus.instr_out, bus.mem_rd, d);
      end
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.fetch_busy !== 1'b0 || bus.instr_out !== d ||
        bus.immediate_value !== ref_imm(d) || bus.fetch_err !== 1'b0) begin
      errors++; $display("FAIL consume: got valid=%b busy=%b instr=%h imm=%h err=%b expected 0 0 %h %h 0", bus.instr_valid, bus.fetch_busy, bus.instr_out, bus.immediate_value, bus.fetch_err, d, ref_imm(d));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pc_in = '0; bus.fetch_req = 1'b0; bus.flush = 1'b0; bus.instr_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.mem_rd, bus.mem_addr, bus.instr_out, bus.immediate_value, bus.instr_valid, bus.fetch_busy, bus.fetch_err} !== '0) begin
      errors++; $display("FAIL reset_state: got rd=%b addr=%h instr=%h imm=%h valid=%b busy=%b err=%b expected all 0", bus.mem_rd, bus.mem_addr, bus.instr_out, bus.immediate_value, bus.instr_valid, bus.fetch_busy, bus.fetch_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    fetch_one(16'h0004, 16'h3A05, 0, 0);
  endtask

  task automatic test_wait_negative_imm();
    fetch_one(16'h0020, 16'h12F0, 3, 1);
    checks++;
    if (bus.immediate_value !== 16'hFFF0) begin
      errors++; $display("FAIL neg_imm: got %h expected fff0", bus.immediate_value);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d0, d1;
    d0 = 16'($urandom); d1 = 16'($urandom);
    mq_wait.push_back(0); mq_data.push_back(d0);
    mq_wait.push_back(0); mq_data.push_back(d1);
    bus.pc_in = 16'h0010; bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    tick();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_out !== d0) begin
      errors++; $display("FAIL b2b_first: got valid=%b instr=%h expected 1 %h", bus.instr_valid, bus.instr_out, d0);
    end
    bus.pc_in = 16'h0011; bus.fetch_req = 1'b1; bus.instr_ready = 1'b1;
    tick();
    bus.fetch_req = 1'b0; bus.instr_ready = 1'b0;
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0011 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_relaunch: got rd=%b addr=%h valid=%b expected 1 0011 0", bus.mem_rd, bus.mem_addr, bus.instr_valid);
    end
    tick();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_out !== d1 || bus.immediate_value !== ref_imm(d1)) begin
      errors++; $display("FAIL b2b_second: got valid=%b instr=%h imm=%h expected 1 %h %h", bus.instr_valid, bus.instr_out, bus.immediate_value, d1, ref_imm(d1));
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_flush();
    int unsigned cyc;
    bit          saw_valid;
    mq_wait.push_back(2); mq_data.push_back(16'hBEEF);
    bus.pc_in = 16'h0030; bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.fetch_busy !== 1'b1 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drain: got rd=%b busy=%b valid=%b expected 1 1 0", bus.mem_rd, bus.fetch_busy, bus.instr_valid);
    end
    cyc = 0; saw_valid = 1'b0;
    while (bus.fetch_busy === 1'b1 && cyc < 20) begin
      tick(); cyc++;
      if (bus.instr_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++;
    if (bus.fetch_busy !== 1'b0 || bus.mem_rd !== 1'b0 || saw_valid) begin
      errors++; $display("FAIL flush_idle: got busy=%b rd=%b saw_valid=%0d expected 0 0 0", bus.fetch_busy, bus.mem_rd, saw_valid);
    end
    fetch_one(16'h0031, 16'h5A81, 1, 0);

    // flush and mem_ready arriving together
    mq_wait.push_back(0); mq_data.push_back(16'h1111);
    bus.pc_in = 16'h0040; bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.fetch_busy !== 1'b0 || bus.mem_rd !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr_out === 16'h1111) begin
      errors++; $display("FAIL flush_ready_same: got busy=%b rd=%b valid=%b instr=%h expected 0 0 0 not 1111", bus.fetch_busy, bus.mem_rd, bus.instr_valid, bus.instr_out);
    end

    // flush in VALID beats a simultaneous fetch_req
    mq_wait.push_back(0); mq_data.push_back(16'h2277);
    bus.pc_in = 16'h0050; bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    tick();
    bus.flush = 1'b1; bus.fetch_req = 1'b1; bus.pc_in = 16'h0051;
    tick();
    bus.flush = 1'b0; bus.fetch_req = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b0 || bus.fetch_busy !== 1'b0 || bus.instr_out !== 16'h2277) begin
      errors++; $display("FAIL flush_valid: got valid=%b rd=%b busy=%b instr=%h expected 0 0 0 2277", bus.instr_valid, bus.mem_rd, bus.fetch_busy, bus.instr_out);
    end
    tick();
  endtask

  task automatic test_async_reset();
    bit bad;
    mq_wait.push_back(5); mq_data.push_back(16'h7777);
    bus.pc_in = 16'h0060; bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_rd, bus.mem_addr, bus.instr_out, bus.immediate_value, bus.instr_valid, bus.fetch_busy, bus.fetch_err} !== '0) begin
      errors++; $display("FAIL async_reset: got rd=%b addr=%h instr=%h imm=%h valid=%b busy=%b err=%b expected all 0", bus.mem_rd, bus.mem_addr, bus.instr_out, bus.immediate_value, bus.instr_valid, bus.fetch_busy, bus.fetch_err);
    end
    rst = 1'b0;
    force_ready = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (bus.instr_valid !== 1'b0 || bus.fetch_busy !== 1'b0 || bus.mem_rd !== 1'b0 || bus.instr_out !== 16'h0000) bad = 1'b1;
    end
    force_ready = 1'b0;
    tick();
    checks++;
    if (bad) begin
      errors++; $display("FAIL stale_ready: got a reaction to mem_ready after reset expected none (valid=%b busy=%b)", bus.instr_valid, bus.fetch_busy);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned cyc;
    mq_wait.push_back(1000); mq_data.push_back(16'h0BAD);
    bus.pc_in = 16'h0070; bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    cyc = 0;
    while (bus.fetch_err !== 1'b1 && cyc < 40) begin
      tick(); cyc++;
    end
    checks++;
    if (cyc !== 15 || bus.mem_rd !== 1'b0 || bus.fetch_busy !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL timeout: got cyc=%0d rd=%b busy=%b valid=%b expected 15 0 0 0", cyc, bus.mem_rd, bus.fetch_busy, bus.instr_valid);
    end
    tick();
    checks++;
    if (bus.fetch_err !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: got err=%b expected 0", bus.fetch_err);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      fetch_one(16'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wait_negative_imm();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
